// File: rtl/range_stream_merger.sv
// Coalesces ascending (start,end) pairs, delivered in blocks of up to 8, into
// disjoint merged ranges streamed one per cycle, with a running coverage total.
module range_stream_merger #(
  parameter int FIELD_W   = 64,
  parameter int MERGE_ADJ = 1,
  parameter int TOTAL_W   = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   valid_in,
  output logic                   ready_in,
  input  logic [16*FIELD_W-1:0]  pairs_in_flat,
  input  logic [3:0]             count_in,
  input  logic                   last_in,
  output logic                   valid_out,
  input  logic                   ready_out,
  output logic [2*FIELD_W-1:0]   range_out,
  output logic                   last_out,
  output logic                   done,
  output logic [TOTAL_W-1:0]     total_out
);

  // state | meaning
  // IDLE  | waiting for a block; accumulator may carry across blocks
  // DRAIN | walking buffered elements 0..cnt-1, one per cycle
  // FLUSH | end of stream: emit the pending range (if any) and pulse done
  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

  state_t                 state;
  logic [16*FIELD_W-1:0]  blk;
  logic [3:0]             cnt;
  logic [3:0]             idx;
  logic                   lst;
  logic                   acc_valid;
  logic                   stream_open;
  logic [FIELD_W-1:0]     acc_start;
  logic [FIELD_W-1:0]     acc_end;

  logic [FIELD_W-1:0]     e_start;
  logic [FIELD_W-1:0]     e_end;
  logic [FIELD_W:0]       acc_end_p1;
  logic                   overlap;
  logic                   slot_free;
  logic                   last_elem;
  logic                   step;
  logic [TOTAL_W-1:0]     acc_len;

  always_comb begin
    e_start = '0;
    e_end   = '0;
    for (int i = 0; i < 8; i++) begin
      if (idx[2:0] == i[2:0]) begin
        e_start = blk[i*2*FIELD_W+FIELD_W +: FIELD_W];
        e_end   = blk[i*2*FIELD_W +: FIELD_W];
      end
    end
  end

  // One extra bit so an all-ones end does not wrap and falsely absorb start 0.
  assign acc_end_p1 = {1'b0, acc_end} + (FIELD_W+1)'(1);
  assign overlap    = (MERGE_ADJ != 0) ? ({1'b0, e_start} <= acc_end_p1)
                                       : (e_start <= acc_end);
  assign acc_len    = TOTAL_W'(acc_end - acc_start) + TOTAL_W'(1);
  assign slot_free  = !valid_out || ready_out;
  assign last_elem  = ((idx + 4'd1) == cnt);
  assign step       = !acc_valid || overlap || slot_free;
  assign ready_in   = (state == IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      blk         <= '0;
      cnt         <= '0;
      idx         <= '0;
      lst         <= 1'b0;
      acc_valid   <= 1'b0;
      stream_open <= 1'b0;
      acc_start   <= '0;
      acc_end     <= '0;
      valid_out   <= 1'b0;
      range_out   <= '0;
      last_out    <= 1'b0;
      done        <= 1'b0;
      total_out   <= '0;
    end else begin
      done <= 1'b0;
      if (valid_out && ready_out) begin
        valid_out <= 1'b0;
        last_out  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (valid_in) begin
            blk         <= pairs_in_flat;
            cnt         <= (count_in > 4'd8) ? 4'd8 : count_in;
            lst         <= last_in;
            idx         <= '0;
            stream_open <= 1'b1;
            if (!stream_open)
              total_out <= '0;
            if (count_in == 4'd0)
              state <= last_in ? FLUSH : IDLE;
            else
              state <= DRAIN;
          end
        end

        DRAIN: begin
          if (!acc_valid) begin
            acc_valid <= 1'b1;
            acc_start <= e_start;
            acc_end   <= e_end;
          end else if (overlap) begin
            if (e_end > acc_end)
              acc_end <= e_end;
          end else if (slot_free) begin
            valid_out <= 1'b1;
            last_out  <= 1'b0;
            range_out <= {acc_start, acc_end};
            total_out <= total_out + acc_len;
            acc_start <= e_start;
            acc_end   <= e_end;
          end

          if (step) begin
            if (last_elem) begin
              idx   <= '0;
              state <= lst ? FLUSH : IDLE;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end

        FLUSH: begin
          if (!acc_valid) begin
            done        <= 1'b1;
            stream_open <= 1'b0;
            state       <= IDLE;
          end else if (slot_free) begin
            valid_out   <= 1'b1;
            last_out    <= 1'b1;
            range_out   <= {acc_start, acc_end};
            total_out   <= total_out + acc_len;
            acc_valid   <= 1'b0;
            done        <= 1'b1;
            stream_open <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_range_stream_merger.sv
// Directed bench for range_stream_merger: single-block vector table plus
// multi-block, backpressure, reset and non-adjacent-merge sequences.
module tb_range_stream_merger;

  logic          clock;
  logic          reset;
  logic          valid_in, valid_in_b;
  logic          ready_in, ready_in_b;
  logic [1023:0] pairs_in_flat;
  logic [3:0]    count_in;
  logic          last_in;
  logic          valid_out, valid_out_b;
  logic          ready_out;
  logic [127:0]  range_out, range_out_b;
  logic          last_out, last_out_b;
  logic          done, done_b;
  logic [63:0]   total_out, total_out_b;

  range_stream_merger #(.FIELD_W(64), .MERGE_ADJ(1), .TOTAL_W(64)) dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .pairs_in_flat(pairs_in_flat), .count_in(count_in), .last_in(last_in),
    .valid_out(valid_out), .ready_out(ready_out), .range_out(range_out),
    .last_out(last_out), .done(done), .total_out(total_out));

  range_stream_merger #(.FIELD_W(64), .MERGE_ADJ(0), .TOTAL_W(64)) dut_b (
    .clock(clock), .reset(reset), .valid_in(valid_in_b), .ready_in(ready_in_b),
    .pairs_in_flat(pairs_in_flat), .count_in(count_in), .last_in(last_in),
    .valid_out(valid_out_b), .ready_out(ready_out), .range_out(range_out_b),
    .last_out(last_out_b), .done(done_b), .total_out(total_out_b));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int done_cnt_b = 0;
  logic [128:0] q_a[$];
  logic [128:0] q_b[$];

  typedef struct packed {
    logic [7:0][63:0] s;
    logic [7:0][63:0] e;
    logic [7:0][63:0] xs;
    logic [7:0][63:0] xe;
    logic [3:0]       cnt;
    logic [3:0]       nx;
    logic [63:0]      xt;
  } vec_t;

  vec_t tv[7];

  task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output capture and stall-stability check, all on pre-edge values.
  logic         p_valid = 1'b0;
  logic         p_ready = 1'b0;
  logic [127:0] p_range = '0;
  always @(posedge clock) begin
    if (!reset && p_valid && !p_ready) begin
      n_cmp++;
      if (!valid_out || range_out !== p_range) begin
        n_bad++;
        $display("FAIL stall_hold: got v=%0b %0h expected v=1 %0h", valid_out, range_out, p_range);
      end
    end
    p_valid = valid_out && !reset;
    p_ready = ready_out;
    p_range = range_out;
    if (!reset && valid_out && ready_out)     q_a.push_back({last_out, range_out});
    if (!reset && valid_out_b && ready_out)   q_b.push_back({last_out_b, range_out_b});
    if (!reset && done)   done_cnt++;
    if (!reset && done_b) done_cnt_b++;
  end

  task automatic set_pairs(input logic [7:0][63:0] s, input logic [7:0][63:0] e);
    for (int i = 0; i < 8; i++) pairs_in_flat[i*128 +: 128] = {s[i], e[i]};
  endtask

  task automatic send(input logic [3:0] c, input logic l);
    int t;
    count_in = c;
    last_in  = l;
    valid_in = 1'b1;
    for (t = 0; t < 300 && !ready_in; t++) @(negedge clock);
    if (!ready_in) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got ready_in=0 expected 1");
    end
    @(negedge clock);
    valid_in = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int which_b);
    int t;
    for (t = 0; t < 300; t++) begin
      if ((which_b == 0 && done_cnt > prev) || (which_b != 0 && done_cnt_b > prev)) break;
      @(negedge clock);
    end
    if (t == 300) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got no done expected done pulse");
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic chk_range(input string name, input logic [128:0] q[$], input int i,
                           input logic [63:0] xs, input logic [63:0] xe, input logic xl);
    logic [128:0] got;
    got = (i < q.size()) ? q[i] : '0;
    chk(name, got, {xl, xs, xe});
  endtask

  initial begin
    int base;
    bit pat[4];
    bit bp_en;
    logic [7:0][63:0] s0, e0;

    // Single-block vectors, each run as a whole stream with last_in=1.
    for (int v = 0; v < 7; v++) tv[v] = '0;
    tv[0].s[0]=3;  tv[0].e[0]=5;  tv[0].s[1]=10; tv[0].e[1]=14;
    tv[0].s[2]=12; tv[0].e[2]=18; tv[0].s[3]=16; tv[0].e[3]=20;
    tv[0].cnt=4; tv[0].nx=2; tv[0].xs[0]=3; tv[0].xe[0]=5; tv[0].xs[1]=10; tv[0].xe[1]=20; tv[0].xt=14;

    tv[1].s[0]=1; tv[1].e[0]=4; tv[1].s[1]=5; tv[1].e[1]=7;
    tv[1].cnt=2; tv[1].nx=1; tv[1].xs[0]=1; tv[1].xe[0]=7; tv[1].xt=7;

    tv[2].s[0]=0;   tv[2].e[0]=0;   tv[2].s[1]=2;  tv[2].e[1]=3;
    tv[2].s[2]=10;  tv[2].e[2]=19;  tv[2].s[3]=30; tv[2].e[3]=30;
    tv[2].s[4]=40;  tv[2].e[4]=41;  tv[2].s[5]=50; tv[2].e[5]=59;
    tv[2].s[6]=70;  tv[2].e[6]=70;  tv[2].s[7]=100; tv[2].e[7]=199;
    tv[2].cnt=8; tv[2].nx=8; tv[2].xs=tv[2].s; tv[2].xe=tv[2].e; tv[2].xt=127;

    tv[3].s[0]=64'hFFFF_FFFF_FFFF_FFF0; tv[3].e[0]=64'hFFFF_FFFF_FFFF_FFFF;
    tv[3].s[1]=64'hFFFF_FFFF_FFFF_FFFF; tv[3].e[1]=64'hFFFF_FFFF_FFFF_FFFF;
    tv[3].cnt=2; tv[3].nx=1; tv[3].xs[0]=64'hFFFF_FFFF_FFFF_FFF0; tv[3].xe[0]=64'hFFFF_FFFF_FFFF_FFFF; tv[3].xt=16;

    tv[4].s[0]=5; tv[4].e[0]=100; tv[4].s[1]=6;   tv[4].e[1]=7;
    tv[4].s[2]=50; tv[4].e[2]=60; tv[4].s[3]=101; tv[4].e[3]=101;
    tv[4].cnt=4; tv[4].nx=1; tv[4].xs[0]=5; tv[4].xe[0]=101; tv[4].xt=97;

    tv[5].s[0]=1; tv[5].e[0]=2; tv[5].s[1]=20; tv[5].e[1]=30;
    for (int i = 2; i < 8; i++) begin tv[5].s[i]=0; tv[5].e[i]=1000; end
    tv[5].cnt=2; tv[5].nx=2; tv[5].xs[0]=1; tv[5].xe[0]=2; tv[5].xs[1]=20; tv[5].xe[1]=30; tv[5].xt=13;

    tv[6].cnt=0; tv[6].nx=0; tv[6].xt=0;

    reset = 1'b1; valid_in = 1'b0; valid_in_b = 1'b0; ready_out = 1'b1;
    pairs_in_flat = '0; count_in = '0; last_in = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_ready_in",  ready_in, 1);
    chk("rst_last_out",  last_out, 0);
    chk("rst_done",      done, 0);
    chk("rst_range_out", range_out, 0);
    chk("rst_total_out", total_out, 0);
    reset = 1'b0;
    @(negedge clock);

    for (int v = 0; v < 7; v++) begin
      q_a.delete();
      base = done_cnt;
      set_pairs(tv[v].s, tv[v].e);
      send(tv[v].cnt, 1'b1);
      wait_done(base, 0);
      chk($sformatf("v%0d_n_out", v), q_a.size(), tv[v].nx);
      for (int i = 0; i < 8; i++)
        if (i < int'(tv[v].nx))
          chk_range($sformatf("v%0d_range%0d", v, i), q_a, i, tv[v].xs[i], tv[v].xe[i],
                    (i == int'(tv[v].nx) - 1));
      chk($sformatf("v%0d_total", v), total_out, tv[v].xt);
      chk($sformatf("v%0d_done_cnt", v), done_cnt - base, 1);
    end

    // Touching ranges stay separate when adjacency merging is off.
    q_b.delete();
    base = done_cnt_b;
    set_pairs(tv[1].s, tv[1].e);
    count_in = 2; last_in = 1'b1;
    chk("b_ready_in", ready_in_b, 1);
    valid_in_b = 1'b1;
    @(negedge clock);
    valid_in_b = 1'b0;
    wait_done(base, 1);
    chk("b_n_out", q_b.size(), 2);
    chk_range("b_range0", q_b, 0, 1, 4, 1'b0);
    chk_range("b_range1", q_b, 1, 5, 7, 1'b1);
    chk("b_total", total_out_b, 7);

    // A range spanning a block boundary merges into one.
    q_a.delete();
    base = done_cnt;
    s0 = '0; e0 = '0;
    s0[0]=1;  e0[0]=2;  s0[1]=4;  e0[1]=5;  s0[2]=7;  e0[2]=8;  s0[3]=10; e0[3]=11;
    s0[4]=13; e0[4]=14; s0[5]=16; e0[5]=17; s0[6]=20; e0[6]=30; s0[7]=40; e0[7]=50;
    set_pairs(s0, e0);
    send(8, 1'b0);
    s0 = '0; e0 = '0;
    s0[0]=45; e0[0]=60; s0[1]=58; e0[1]=59; s0[2]=80; e0[2]=90;
    set_pairs(s0, e0);
    send(3, 1'b1);
    wait_done(base, 0);
    chk("blk2_n_out", q_a.size(), 9);
    chk_range("blk2_span", q_a, 7, 40, 60, 1'b0);
    chk_range("blk2_final", q_a, 8, 80, 90, 1'b1);
    base = 0;
    foreach (q_a[i]) if (q_a[i][128]) base++;
    chk("blk2_last_cnt", base, 1);
    chk("blk2_total", total_out, 55);

    // Backpressure: ready_out toggles 1-0-0-1 every cycle.
    q_a.delete();
    base = done_cnt;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    bp_en = 1;
    fork
      begin
        int k;
        k = 0;
        while (bp_en) begin
          ready_out = pat[k % 4];
          k++;
          @(negedge clock);
        end
      end
    join_none
    set_pairs(tv[2].s, tv[2].e);
    send(8, 1'b1);
    wait_done(base, 0);
    bp_en = 0;
    @(negedge clock);
    ready_out = 1'b1;
    repeat (3) @(negedge clock);
    chk("bp_n_out", q_a.size(), 8);
    for (int i = 0; i < 8; i++)
      chk_range($sformatf("bp_range%0d", i), q_a, i, tv[2].s[i], tv[2].e[i], (i == 7));
    chk("bp_total", total_out, 127);

    // Reset while DRAIN is stalled on a full output slot.
    ready_out = 1'b0;
    set_pairs(tv[2].s, tv[2].e);
    send(8, 1'b1);
    repeat (4) @(negedge clock);
    chk("pre_rst_stalled", valid_out, 1);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_valid_out", valid_out, 0);
    chk("mid_rst_ready_in", ready_in, 1);
    chk("mid_rst_total", total_out, 0);
    reset = 1'b0;
    ready_out = 1'b1;
    q_a.delete();
    base = done_cnt;
    s0 = '0; e0 = '0;
    s0[0] = 7; e0[0] = 9;
    set_pairs(s0, e0);
    send(1, 1'b1);
    wait_done(base, 0);
    chk("post_rst_n_out", q_a.size(), 1);
    chk_range("post_rst_range", q_a, 0, 7, 9, 1'b1);
    chk("post_rst_total", total_out, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/range_stream_merger.md
Name: range_stream_merger

Overview:
- Consumer at the far end of the 8-wide pair-sorting path: accepts flat blocks of 8 (start,end) pairs already in ascending start order and serializes them at one pair per cycle.
- Coalesces overlapping inclusive ranges and streams out disjoint merged ranges over a valid/ready interface.
- Accumulates total covered length, reported at end of stream.
- Downstream of the sorter/merge tree in the interval-merge flow.

Parameters:
- FIELD_W, 64, width of each start/end field.
- MERGE_ADJ, 1, when 1 ranges that touch (start == cur_end+1) also merge; when 0 only overlapping ranges merge.
- TOTAL_W, 64, width of total coverage accumulator.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous active-high reset
- valid_in  in  1  block offered
- ready_in  out  1  block accepted when valid_in && ready_in
- pairs_in_flat  in  16*FIELD_W  element i at bits [i*2*FIELD_W +: 2*FIELD_W]; start in upper FIELD_W, end in lower FIELD_W
- count_in  in  4  number of valid elements 0..8 (elements 0..count_in-1)
- last_in  in  1  block is final of stream
- valid_out  out  1  merged range available
- ready_out  in  1  downstream accepts when valid_out && ready_out
- range_out  out  2*FIELD_W  {start,end}, same packing as input element
- last_out  out  1  qualifies final range of stream
- done  out  1  one-cycle pulse at stream completion
- total_out  out  TOTAL_W  sum of (end-start+1) over emitted ranges of current stream

Behaviour:
- Reset (synchronous, active-high), clock clock: state IDLE, ready_in=1, valid_out=0, last_out=0, done=0, range_out=0, total_out=0, accumulator invalid, idx=0. Reset mid-stream discards buffered block and accumulator.
- Output slot: registered; valid_out holds with range_out/last_out stable until ready_out. slot_free = !valid_out || ready_out.
- IDLE: ready_in=1. On accept: latch block, count, last; idx=0; if count_in==0 go FLUSH if last_in else stay IDLE; else go DRAIN. First accept of a stream (accumulator invalid and previous stream done) clears total_out.
- DRAIN: ready_in=0. Each cycle examine element idx (e):
  - acc invalid: acc<=e, advance.
  - e.start <= acc.end (or <= acc.end+1 when MERGE_ADJ): acc.end<=max(acc.end,e.end), advance. No output needed, never stalls.
  - otherwise: if slot_free, emit acc (last_out=0), total_out += acc.end-acc.start+1, acc<=e, advance; else stall (idx unchanged).
  - advance from idx==count-1: to FLUSH if last else IDLE.
- FLUSH: if acc valid: wait slot_free, emit acc with last_out=1, add length, acc invalid, done=1 that cycle, go IDLE. If acc invalid: done=1 immediately, no range emitted, go IDLE.
- Arithmetic: comparisons unsigned; acc.end+1 computed at FIELD_W+1 bits (no wrap at all-ones); total_out wraps modulo 2^TOTAL_W.
- Elements at idx>=count ignored. Input order not checked; unsorted input gives unspecified ranges but no hang.
- Throughput: one element/cycle absent backpressure; block of n elements occupies n DRAIN cycles plus accept cycle.

Test Plan:
- Single block count=4, last=1: (3,5),(10,14),(12,18),(16,20), ready_out=1 -> ranges (3,5),(10,20) with last on second; done; total_out=14.
- MERGE_ADJ=1: (1,4),(5,7) -> single (1,7) total 7; MERGE_ADJ=0 same input -> (1,4),(5,7) total 7.
- Two blocks of 8 with range spanning boundary (block0 ends (40,50), block1 starts (45,60)) -> one merged (40,60); exactly one last_out.
- Backpressure: 8 disjoint ranges, ready_out toggled 1-0-0-1 -> no loss/duplication, range_out stable while stalled, 8 outputs in order.
- Empty stream: count_in=0, last_in=1 -> no valid_out, done pulse, total_out=0.
- Reset asserted mid-DRAIN -> next cycle valid_out=0, ready_in=1; fresh stream (7,9) -> (7,9), total 3.
